// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared four-bank main memory port.
// Grants whole line bursts, holds through read latency, and returns read-valid to the owner only.
module mem_port_arbiter #(
  parameter int unsigned BURST = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNTW  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic        rd0,
  input  logic        rd1,
  input  logic        mem_stall,
  output logic        gnt0,
  output logic        gnt1,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

  state_t          state;
  logic            owner;
  logic            last_owner;
  logic [CNTW-1:0] beats;
  logic [CNTW-1:0] drain;
  logic [LAT-1:0]  pipe_vld;
  logic [LAT-1:0]  pipe_own;

  logic            o_req;
  logic            o_wr;
  logic            o_rd;
  logic [DW-1:0]   o_addr;
  logic [DW-1:0]   o_data;
  logic            live;
  logic            conflict;
  logic            accept;

  // Owner-side mux; the non-owner's inputs never reach memory.
  assign o_req  = owner ? req1  : req0;
  assign o_wr   = owner ? wr1   : wr0;
  assign o_rd   = owner ? rd1   : rd0;
  assign o_addr = owner ? addr1 : addr0;
  assign o_data = owner ? data1 : data0;

  assign live     = (state == S_BURST) & o_req;
  assign conflict = o_wr & o_rd;

  assign mem_wr   = live & o_wr & ~o_rd;
  assign mem_rd   = live & o_rd & ~o_wr;
  assign mem_addr = (state == S_BURST) ? o_addr : '0;
  assign mem_data = (state == S_BURST) ? o_data : '0;
  assign accept   = (mem_wr | mem_rd) & ~mem_stall;

  assign busy    = (state != S_IDLE);
  assign gnt0    = busy & ~owner;
  assign gnt1    = busy & owner;
  assign rvalid0 = pipe_vld[LAT-1] & ~pipe_own[LAT-1];
  assign rvalid1 = pipe_vld[LAT-1] & pipe_own[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      beats      <= '0;
      drain      <= '0;
      err        <= 1'b0;
      pipe_vld   <= '0;
      pipe_own   <= '0;
    end else begin
      // Read-return tag pipe: one slot per cycle of memory latency.
      pipe_vld[0] <= mem_rd & ~mem_stall;
      pipe_own[0] <= owner;
      for (int i = 1; i < int'(LAT); i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end

      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            owner <= (req0 & req1) ? ~last_owner : req1;
            beats <= '0;
            state <= S_BURST;
          end
        end
        S_BURST: begin
          if (!o_req) begin
            drain <= CNTW'(LAT);
            state <= S_DRAIN;
          end else if (conflict) begin
            err <= 1'b1;
          end else if (accept) begin
            beats <= beats + CNTW'(1);
            if (beats == CNTW'(BURST - 1)) begin
              drain <= CNTW'(LAT);
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          drain <= drain - CNTW'(1);
          if (drain == CNTW'(1)) begin
            last_owner <= owner;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_rvalid_onehot: assert property (@(posedge clk) disable iff (rst) !(rvalid0 && rvalid1));
  a_strobe_owned:  assert property (@(posedge clk) disable iff (rst) !((mem_wr || mem_rd) && !(gnt0 || gnt1)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: requester drivers with a timestamp scoreboard
// for read returns and a round-robin model of grant order.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_v [2];
  logic [15:0] addr_v [2];
  logic [15:0] data_v [2];
  logic        wr_v [2];
  logic        rd_v [2];
  logic        mem_stall;

  logic        gnt0, gnt1, mem_wr, mem_rd, rvalid0, rvalid1, busy, err;
  logic [15:0] mem_addr, mem_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rv_q0[$];
  int rv_q1[$];
  int rv_cnt [2];
  logic e0, e1;
  int last_owner_m;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req_v[0]), .req1(req_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]),
    .data0(data_v[0]), .data1(data_v[1]),
    .wr0(wr_v[0]), .wr1(wr_v[1]),
    .rd0(rd_v[0]), .rd1(rd_v[1]),
    .mem_stall(mem_stall),
    .gnt0(gnt0), .gnt1(gnt1),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .busy(busy), .err(err)
  );

  function automatic logic gnt_of(input int o);
    return (o == 0) ? gnt0 : gnt1;
  endfunction

  // Cycle counter; a reset drops every read still in flight.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rv_q0.delete();
      rv_q1.delete();
    end
  end

  // Read-return scoreboard: rvalidN is due exactly at the recorded cycles.
  always @(negedge clk) begin
    if (!rst) begin
      while (rv_q0.size() > 0 && rv_q0[0] < cyc) void'(rv_q0.pop_front());
      while (rv_q1.size() > 0 && rv_q1[0] < cyc) void'(rv_q1.pop_front());
      e0 = (rv_q0.size() > 0) && (rv_q0[0] == cyc);
      e1 = (rv_q1.size() > 0) && (rv_q1[0] == cyc);
      if (e0) void'(rv_q0.pop_front());
      if (e1) void'(rv_q1.pop_front());
      n_tests++;
      if (rvalid0 !== e0) begin
        n_fail++;
        $display("FAIL rvalid0 cyc=%0d got=%b exp=%b", cyc, rvalid0, e0);
      end
      n_tests++;
      if (rvalid1 !== e1) begin
        n_fail++;
        $display("FAIL rvalid1 cyc=%0d got=%b exp=%b", cyc, rvalid1, e1);
      end
      if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
        n_fail++;
        $display("FAIL gnt_onehot cyc=%0d got=11 exp=not both", cyc);
      end
      if (rvalid0 === 1'b1) rv_cnt[0]++;
      if (rvalid1 === 1'b1) rv_cnt[1]++;
    end
  end

  // One requester burst; waits for its grant with the first beat already presented.
  task automatic do_burst(input int o, input logic [15:0] base, input logic [15:0] dbase,
                          input bit is_wr, input int stall_pct, input int stall_b, input int stall_n,
                          input int err_b, input int stop_after, input bit keep_req,
                          output int wait_cyc);
    int b, guard, left;
    bit got, err_done, bad;
    logic [15:0] ea, ed;
    b = 0; guard = 0; left = stall_n; got = 0; err_done = 0; wait_cyc = 0;
    req_v[o] = 1'b1;
    while (b < stop_after && guard < 200) begin
      bad = (b == err_b) && !err_done;
      ea = base + 16'(2 * b);
      ed = dbase + 16'(b);
      addr_v[o] = ea;
      data_v[o] = ed;
      wr_v[o] = is_wr | bad;
      rd_v[o] = !is_wr | bad;
      if (got) begin
        if (b == stall_b && left > 0) begin
          mem_stall = 1'b1;
          left--;
        end else begin
          mem_stall = ($urandom_range(99) < 32'(stall_pct));
        end
      end
      @(negedge clk);
      if (gnt_of(o) === 1'b1) begin
        got = 1;
        n_tests++;
        if (mem_addr !== ea || mem_wr !== (is_wr && !bad) || mem_rd !== (!is_wr && !bad) ||
            gnt_of(1 - o) !== 1'b0 || (is_wr && !bad && mem_data !== ed)) begin
          n_fail++;
          $display("FAIL beat o=%0d b=%0d got addr=%h data=%h wr=%b rd=%b exp addr=%h data=%h wr=%b rd=%b",
                   o, b, mem_addr, mem_data, mem_wr, mem_rd, ea, ed, is_wr && !bad, !is_wr && !bad);
        end
        if (bad) err_done = 1;
        else if (!mem_stall) begin
          if (!is_wr) begin
            if (o == 0) rv_q0.push_back(cyc + LAT);
            else rv_q1.push_back(cyc + LAT);
          end
          b++;
        end
      end else if (got) begin
        n_fail++;
        $display("FAIL grant_lost o=%0d b=%0d got gnt=0 exp gnt=1", o, b);
        break;
      end else begin
        wait_cyc++;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL burst_timeout o=%0d got beats=%0d exp beats=%0d", o, b, stop_after);
    end
    wr_v[o] = 1'b0;
    rd_v[o] = 1'b0;
    if (got) mem_stall = 1'b0;
    req_v[o] = keep_req;
  endtask

  // Counts busy cycles until IDLE; bounded.
  task automatic settle(output int n);
    int g;
    n = 0; g = 0;
    while (g < 20) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      @(posedge clk); #1;
      g++;
    end
    n_tests++;
    if (g >= 20) begin
      n_fail++;
      $display("FAIL settle_timeout got busy=%b exp busy=0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if ({gnt0, gnt1, busy, err, mem_wr, mem_rd, rvalid0, rvalid1} !== 8'h00 ||
        mem_addr !== 16'h0 || mem_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got ctl=%b addr=%h data=%h exp ctl=00000000 addr=0 data=0",
               {gnt0, gnt1, busy, err, mem_wr, mem_rd, rvalid0, rvalid1}, mem_addr, mem_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_owner_m = 1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got busy=%b gnt=%b%b exp 0 00", busy, gnt0, gnt1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fill();
    int w, c0;
    logic exp_g;
    c0 = rv_cnt[1];
    do_burst(1, 16'h1000, 16'h0, 1'b0, 0, -1, 0, -1, 4, 1'b0, w);
    n_tests++;
    if (w != 1) begin
      n_fail++;
      $display("FAIL fill_grant_latency got=%0d exp=1", w);
    end
    for (int i = 0; i < 3; i++) begin
      exp_g = (i < 2);
      @(negedge clk);
      n_tests++;
      if (gnt1 !== exp_g || busy !== exp_g || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_drain i=%0d got gnt1=%b busy=%b exp %b", i, gnt1, busy, exp_g);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (rv_cnt[1] - c0 != 4) begin
      n_fail++;
      $display("FAIL fill_rvalid_count got=%0d exp=4", rv_cnt[1] - c0);
    end
    last_owner_m = 1;
  endtask

  task automatic test_round_robin();
    int w0, w1, win, n;
    for (int r = 0; r < 2; r++) begin
      win = 1 - last_owner_m;
      fork
        do_burst(0, 16'h0200, 16'h0, 1'b0, 0, -1, 0, -1, 4, 1'b0, w0);
        do_burst(1, 16'($urandom) & 16'hFFF8, 16'h0, 1'b0, 0, -1, 0, -1, 4, 1'b0, w1);
      join
      n_tests++;
      if ((win == 0 && (w0 != 1 || w1 != 8)) || (win == 1 && (w1 != 1 || w0 != 8))) begin
        n_fail++;
        $display("FAIL rr_order r=%0d got wait0=%0d wait1=%0d exp winner=%0d waits 1/8", r, w0, w1, win);
      end
      last_owner_m = 1 - win;
      settle(n);
    end
  endtask

  task automatic test_writeback_fill();
    int w, n, c0;
    logic [15:0] base;
    logic exp_g;
    base = 16'($urandom) & 16'hFFF8;
    c0 = rv_cnt[1];
    do_burst(1, base, 16'hA5A0, 1'b1, 0, -1, 0, -1, 4, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      exp_g = (i < 2);
      @(negedge clk);
      n_tests++;
      if (gnt1 !== exp_g || mem_wr !== 1'b0 || mem_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_bubble i=%0d got gnt1=%b exp %b", i, gnt1, exp_g);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (rv_cnt[1] != c0) begin
      n_fail++;
      $display("FAIL wb_no_rvalid got=%0d exp=0", rv_cnt[1] - c0);
    end
    do_burst(1, base, 16'h0, 1'b0, 0, -1, 0, -1, 4, 1'b0, w);
    n_tests++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL wb_regrant got wait=%0d exp=0", w);
    end
    settle(n);
    n_tests++;
    if (rv_cnt[1] - c0 != 4) begin
      n_fail++;
      $display("FAIL wb_fill_rvalid got=%0d exp=4", rv_cnt[1] - c0);
    end
    last_owner_m = 1;
  endtask

  task automatic test_stall();
    int o, w, n, c0;
    o = int'($urandom_range(1));
    c0 = rv_cnt[o];
    do_burst(o, 16'($urandom) & 16'hFFF8, 16'h0, 1'b0, 0, 1, 3, -1, 4, 1'b0, w);
    settle(n);
    n_tests++;
    if (n != 2 || rv_cnt[o] - c0 != 4) begin
      n_fail++;
      $display("FAIL stall_burst got drain=%0d rvalid=%0d exp drain=2 rvalid=4", n, rv_cnt[o] - c0);
    end
    last_owner_m = o;
  endtask

  task automatic test_err_abort();
    int w, n, c0;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pre got=%b exp=0", err);
    end
    do_burst(0, 16'h3000, 16'h0, 1'b0, 0, -1, 0, 2, 4, 1'b0, w);
    settle(n);
    n_tests++;
    if (err !== 1'b1 || n != 2) begin
      n_fail++;
      $display("FAIL err_set got err=%b drain=%0d exp err=1 drain=2", err, n);
    end
    c0 = rv_cnt[0];
    do_burst(0, 16'h3100, 16'h0, 1'b0, 0, -1, 0, -1, 2, 1'b0, w);
    settle(n);
    n_tests++;
    if (n != 3 || rv_cnt[0] - c0 != 2 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL abort got drain=%0d rvalid=%0d err=%b exp drain=3 rvalid=2 err=1",
               n, rv_cnt[0] - c0, err);
    end
    last_owner_m = 0;
  endtask

  task automatic test_random();
    int w0, w1, n, win, c0, c1, x0, x1;
    bit both, wr0_m, wr1_m;
    for (int it = 0; it < 6; it++) begin
      both  = ($urandom_range(1) == 1);
      wr0_m = ($urandom_range(1) == 1);
      wr1_m = ($urandom_range(1) == 1);
      c0 = rv_cnt[0]; c1 = rv_cnt[1];
      if (both) begin
        win = 1 - last_owner_m;
        fork
          do_burst(0, 16'($urandom), 16'($urandom), wr0_m, 25, -1, 0, -1, 4, 1'b0, w0);
          do_burst(1, 16'($urandom), 16'($urandom), wr1_m, 25, -1, 0, -1, 4, 1'b0, w1);
        join
        n_tests++;
        if ((win == 0 && !(w0 == 1 && w1 > 8)) && (win == 0 && !(w0 == 1 && w1 == 8))) begin
          n_fail++;
          $display("FAIL rand_order it=%0d got wait0=%0d wait1=%0d exp winner=0", it, w0, w1);
        end else if (win == 1 && !(w1 == 1 && w0 >= 8)) begin
          n_fail++;
          $display("FAIL rand_order it=%0d got wait0=%0d wait1=%0d exp winner=1", it, w0, w1);
        end
        last_owner_m = 1 - win;
        x0 = wr0_m ? 0 : 4;
        x1 = wr1_m ? 0 : 4;
      end else begin
        win = int'($urandom_range(1));
        do_burst(win, 16'($urandom), 16'($urandom), (win == 0) ? wr0_m : wr1_m, 25, -1, 0, -1, 4,
                 1'b0, w0);
        n_tests++;
        if (w0 != 1) begin
          n_fail++;
          $display("FAIL rand_single it=%0d got wait=%0d exp=1", it, w0);
        end
        last_owner_m = win;
        x0 = (win == 0 && !wr0_m) ? 4 : 0;
        x1 = (win == 1 && !wr1_m) ? 4 : 0;
      end
      settle(n);
      n_tests++;
      if (n != 2 || rv_cnt[0] - c0 != x0 || rv_cnt[1] - c1 != x1) begin
        n_fail++;
        $display("FAIL rand_returns it=%0d got drain=%0d rv=%0d/%0d exp drain=2 rv=%0d/%0d",
                 it, n, rv_cnt[0] - c0, rv_cnt[1] - c1, x0, x1);
      end
    end
  endtask

  task automatic test_reset_drain();
    int w, c1;
    do_burst(1, 16'h4000, 16'h0, 1'b0, 0, -1, 0, -1, 4, 1'b0, w);
    c1 = rv_cnt[1];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({gnt0, gnt1, busy, err, rvalid0, rvalid1, mem_wr, mem_rd} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_drain got ctl=%b exp ctl=00000000",
               {gnt0, gnt1, busy, err, rvalid0, rvalid1, mem_wr, mem_rd});
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (rv_cnt[1] != c1) begin
      n_fail++;
      $display("FAIL reset_drop got extra rvalid=%0d exp=0", rv_cnt[1] - c1);
    end
    last_owner_m = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_stall = 1'b0;
    rv_cnt[0] = 0;
    rv_cnt[1] = 0;
    last_owner_m = 1;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; addr_v[i] = '0; data_v[i] = '0; wr_v[i] = 1'b0; rd_v[i] = 1'b0;
    end
    test_reset();
    test_single_fill();
    test_round_robin();
    test_writeback_fill();
    test_stall();
    test_err_abort();
    test_random();
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single four-bank main memory port between the instruction-side cache controller (requester 0) and the data-side cache controller (requester 1).
- Grants the port for a whole line burst of fill or writeback beats, then holds it through the memory read latency.
- Round-robin between the two requesters when both are pending.
- Routes address, write data and read strobes to memory, and routes per-beat read-valid back to the owner only.

Parameters:
BURST, 4, beats per line transaction (4 words, offsets 0,2,4,6)
LAT, 2, cycles from accepted mem_rd to returned data
CNTW, 3, width of beat/drain counters (must hold max(BURST,LAT))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req0 / req1  in  1  requester wants the port; held high for the whole burst
addr0 / addr1  in  16  beat address from requester
data0 / data1  in  16  beat write data from requester
wr0 / wr1  in  1  beat write strobe
rd0 / rd1  in  1  beat read strobe
mem_stall  in  1  memory cannot accept an access this cycle
gnt0 / gnt1  out  1  port owned by requester (one-hot or zero)
mem_addr  out  16  address to memory
mem_data  out  16  write data to memory
mem_wr / mem_rd  out  1  access strobes to memory
rvalid0 / rvalid1  out  1  read data on memory output is for this requester this cycle
busy  out  1  arbiter not IDLE
err  out  1  sticky protocol error

Behaviour:
- Reset: state IDLE, gnt0=gnt1=0, mem_wr=mem_rd=0, mem_addr=mem_data=0, rvalid*=0, beat/drain counters 0, last_owner=1 (requester 0 wins first tie), err=0, read-latency pipe cleared. Reset mid-burst aborts at once with no further memory strobes; any in-flight read returns are dropped, with rvalid held 0.
- All outputs are combinational from registered state plus the owner's inputs. gnt is registered.
- IDLE:
  - No req: remain in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant ~last_owner.
  - The grant takes effect next cycle (1-cycle grant latency) and the state moves to BURST with beats=0.
- BURST:
  - mem_addr/mem_data/mem_wr/mem_rd mirror the owner's inputs. The non-owner's inputs are ignored.
  - A beat is accepted when (wr|rd) & ~mem_stall. Each accepted beat increments beats.
  - When the accepted beat is number BURST-1, go to DRAIN with drain=LAT.
  - Owner wr&rd both high: err<=1, no strobe driven, no beat counted.
  - Owner drops req before BURST beats: abort to DRAIN with drain=LAT. Beats already issued still complete.
- DRAIN:
  - mem_wr=mem_rd=0. gnt stays high.
  - drain decrements each cycle. At drain==1, next state is IDLE, gnt drops, and last_owner<=owner.
  - A new grant can be issued no earlier than the cycle after return to IDLE, so back-to-back bursts have a 1-cycle IDLE bubble.
- Read return: an LAT-deep shift register tags each accepted mem_rd with its owner. rvalidN=1 exactly LAT cycles after acceptance, only for that owner. mem_stall does not delay returns.
- Stall: mem_stall held during BURST freezes beats. There is no timeout.
- Non-owner req is never dropped; it is served after the current owner's DRAIN.
- gnt0 & gnt1 is never 1. Either condition is an assertion failure:
  - both rvalid high at once
  - any strobe while neither gnt is high
- err is sticky until reset.

Test Plan:
- Single data fill: req1=1, rd1 for 4 beats addr 0x1000,0x1002,0x1004,0x1006, no stall -> gnt1 high the cycle after req, mem_rd 4 consecutive cycles with matching addresses, rvalid1 at beat cycles +2, gnt1 low 2 cycles after last beat, busy low next cycle.
- Simultaneous requests from reset: req0=req1=1 -> gnt0 first (4-beat read 0x0200..0x0206), then one IDLE cycle, then gnt1; a second simultaneous pair grants gnt1... round-robin alternates 0,1,0,1.
- Writeback then fill by data side: 4 wr1 beats data 0xA5A0..0xA5A3, then req stays high for 4 rd1 beats as a new burst -> mem_wr ×4 with correct data, rvalid1 never set for writes, second grant after IDLE bubble.
- Stall mid-burst: mem_stall=1 for 3 cycles after beat 1 -> beats stays 1, mem_rd strobes not counted, burst ends after 4 accepted beats; rvalid count for owner equals exactly 4.
- Protocol error and abort: owner drives wr0=rd0=1 on beat 2 -> err=1 sticky, no strobe that cycle. Separately, drop req0 after 2 beats -> DRAIN, 2 rvalid0 pulses only, then IDLE.
- Reset mid-DRAIN: assert rst with 1 read in flight -> next cycle gnt*=0, rvalid*=0, busy=0, err=0, no rvalid ever appears for the dropped read.
